// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
//
// Purpose:
//   Single-port RAM controller behind an SPI slave datapath. Each received word
//   is {cmd, payload}. The controller keeps separate write and read pointers,
//   writes memory, and returns read data through a one-entry valid/ready output
//   slot. A read that finds the slot full with no consumer is dropped and sets
//   a sticky overrun flag.
//
//   cmd 2'b00 : wr_ptr <= payload[ADDR_W-1:0]
//   cmd 2'b01 : mem[wr_ptr] <= payload (dropped if wr_ptr >= MEM_DEPTH)
//   cmd 2'b10 : rd_ptr <= payload[ADDR_W-1:0]
//   cmd 2'b11 : read mem[rd_ptr] into the output slot (0 if out of range)
//
// Optional feature (macro SPI_RAM_AUTOINC_EN):
//   When defined, wr_ptr advances after every cmd 01 (including writes dropped
//   as out of range) and rd_ptr advances after every accepted cmd 11. Pointers
//   wrap from MEM_DEPTH-1 to 0, and an out-of-range pointer also goes to 0.
//   When undefined, pointers change only on cmd 00/10.
//
// Parameters:
//   DATA_W    payload / memory word width
//   ADDR_W    pointer width (ADDR_W <= DATA_W)
//   MEM_DEPTH number of words (MEM_DEPTH <= 2**ADDR_W, any value)
//
// Ports:
//   clk       in   1         clock, rising edge
//   rst_n     in   1         asynchronous active-low reset
//   rx_valid  in   1         din carries a command this cycle
//   din       in   DATA_W+2  {cmd[1:0], payload[DATA_W-1:0]}
//   tx_ready  in   1         consumer accepts dout this cycle
//   tx_valid  out  1         dout holds read data (registered)
//   dout      out  DATA_W    read data (registered)
//   overrun   out  1         sticky: a read was dropped (cleared by reset only)
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] dout,
  output logic              overrun
);

  // Index width actually needed by the storage array; in-range pointers
  // always fit, so the pointer can be truncated to this width safely.
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] DEPTH_L = 32'(MEM_DEPTH);
  localparam logic [31:0] LAST_L  = 32'(MEM_DEPTH - 1);

  localparam logic [1:0] CMD_WPTR  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_RPTR  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Pointer lies inside the physical array.
  function automatic logic in_range(input logic [ADDR_W-1:0] ptr);
    return (32'(ptr) < DEPTH_L);
  endfunction

  // Pointer increment with wrap at MEM_DEPTH-1; out-of-range also goes to 0.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W-1:0] nxt;
    if (32'(ptr) >= LAST_L) begin
      nxt = {ADDR_W{1'b0}};
    end else begin
      nxt = ptr + ADDR_W'(1'b1);
    end
    return nxt;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                tx_valid_q, tx_valid_d;
  logic                overrun_q, overrun_d;

  // Storage is deliberately not reset: contents survive rst_n.
  logic [DATA_W-1:0]   mem_q [0:MEM_DEPTH-1];

  logic [1:0]          cmd_s;
  logic [DATA_W-1:0]   payload_s;
  logic                mem_we_s;
  logic                rd_req_s;
  logic                rd_accept_s;
  logic [DATA_W-1:0]   rd_data_s;

  // Command decode, output-slot state machine and pointer next-state logic.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    overrun_d  = overrun_q;

    cmd_s     = din[DATA_W+1:DATA_W];
    payload_s = din[DATA_W-1:0];

    mem_we_s = rx_valid && (cmd_s == CMD_WRITE) && in_range(wr_ptr_q);
    rd_req_s = rx_valid && (cmd_s == CMD_READ);
    // A read is taken if the slot is empty or is being emptied this edge.
    rd_accept_s = rd_req_s && ((state_q == ST_EMPTY) || tx_ready);

    if (in_range(rd_ptr_q)) begin
      rd_data_s = mem_q[rd_ptr_q[IDX_W-1:0]];
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end

    case (state_q)
      ST_EMPTY: begin
        if (rd_accept_s) begin
          state_d    = ST_FULL;
          dout_d     = rd_data_s;
          tx_valid_d = 1'b1;
        end else begin
          tx_valid_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (rd_accept_s) begin
          // Slot retired and refilled on the same edge.
          dout_d     = rd_data_s;
          tx_valid_d = 1'b1;
        end else if (tx_ready) begin
          state_d    = ST_EMPTY;
          tx_valid_d = 1'b0;
        end else if (rd_req_s) begin
          // Slot held and consumer stalled: read is lost, data stays put.
          overrun_d = 1'b1;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_EMPTY;
        tx_valid_d = 1'b0;
      end
    endcase

    if (rx_valid) begin
      case (cmd_s)
        CMD_WPTR: begin
          wr_ptr_d = payload_s[ADDR_W-1:0];
        end
        CMD_WRITE: begin
`ifdef SPI_RAM_AUTOINC_EN
          wr_ptr_d = next_ptr(wr_ptr_q);
`else
          wr_ptr_d = wr_ptr_q;
`endif
        end
        CMD_RPTR: begin
          rd_ptr_d = payload_s[ADDR_W-1:0];
        end
        CMD_READ: begin
`ifdef SPI_RAM_AUTOINC_EN
          if (rd_accept_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
`else
          rd_ptr_d = rd_ptr_q;
`endif
        end
        default: begin
          wr_ptr_d = wr_ptr_q;
          rd_ptr_d = rd_ptr_q;
        end
      endcase
    end else begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      dout_q     <= {DATA_W{1'b0}};
      tx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Memory write port; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we_s && rst_n) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= payload_s;
    end
  end

  assign tx_valid = tx_valid_q;
  assign dout     = dout_q;
  assign overrun  = overrun_q;

endmodule
